// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives a single-port data memory,
// aligns load data and forwards the write-back record.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_rd2,
  input  logic [2:0]  i_func3,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [4:0]  i_write_reg,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_reg_write,
  output logic [4:0]  o_write_reg,
  output logic        o_exc,
  output logic [1:0]  o_exc_cause
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic [4:0]    ld_rd;
  logic          ld_rw;

  logic        accept;
  logic        is_mem;
  logic        illegal;
  logic        misal;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;

  assign o_stall = (state == WAIT);
  assign accept  = i_valid & ~o_stall;
  assign is_mem  = i_mem_read | i_mem_write;

  always_comb begin
    illegal = 1'b0;
    if (i_mem_read && i_mem_write)
      illegal = 1'b1;
    else if (i_mem_read)
      illegal = (i_func3 == 3'd3) || (i_func3 == 3'd6)
             || (i_func3 == 3'd7);
    else if (i_mem_write)
      illegal = (i_func3 >= 3'd3);
    misal = ~illegal & (
      ((i_func3[1:0] == 2'd1) & i_ALUOutput[0]) |
      ((i_func3[1:0] == 2'd2) & (i_ALUOutput[1:0] != 2'd0)));
  end

  always_comb begin
    be_n = 4'b1111;
    wd_n = i_rd2;
    if (i_mem_write) begin
      unique case (1'b1)
        (i_func3[1:0] == 2'd0): begin
          be_n = 4'b0001 << i_ALUOutput[1:0];
          wd_n = {4{i_rd2[7:0]}};
        end
        (i_func3[1:0] == 2'd1): begin
          be_n = 4'b0011 << {i_ALUOutput[1], 1'b0};
          wd_n = {2{i_rd2[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = i_rd2;
        end
      endcase
    end
  end

  always_comb begin
    rshift = i_dmem_rdata >> {ld_off, 3'b000};
    rbyte  = rshift[7:0];
    rhalf  = ld_off[1] ? i_dmem_rdata[31:16]
                       : i_dmem_rdata[15:0];
    unique case (ld_f3)
      3'd0:    load_val = {{24{rbyte[7]}}, rbyte};
      3'd1:    load_val = {{16{rhalf[15]}}, rhalf};
      3'd4:    load_val = {24'd0, rbyte};
      3'd5:    load_val = {16'd0, rhalf};
      default: load_val = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ld_f3        <= '0;
      ld_off       <= '0;
      ld_rd        <= '0;
      ld_rw        <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_reg_write  <= 1'b0;
      o_write_reg  <= '0;
      o_exc        <= 1'b0;
      o_exc_cause  <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_exc       <= 1'b0;
      o_reg_write <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (!is_mem) begin
            o_valid     <= 1'b1;
            o_result    <= i_ALUOutput;
            o_reg_write <= i_reg_write;
            o_write_reg <= i_write_reg;
          end else if (illegal || misal) begin
            o_valid     <= 1'b1;
            o_result    <= i_ALUOutput;
            o_write_reg <= i_write_reg;
            o_exc       <= 1'b1;
            o_exc_cause <= illegal ? 2'd2 : 2'd1;
          end else begin
            state        <= WAIT;
            cnt          <= '0;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_write;
            o_dmem_addr  <= {i_ALUOutput[31:2], 2'b00};
            o_dmem_be    <= be_n;
            o_dmem_wdata <= wd_n;
            ld_f3        <= i_func3;
            ld_off       <= i_ALUOutput[1:0];
            ld_rd        <= i_write_reg;
            ld_rw        <= i_reg_write;
          end
        end
      end else begin
        if (i_dmem_ack) begin
          state       <= IDLE;
          o_dmem_req  <= 1'b0;
          o_valid     <= 1'b1;
          o_reg_write <= ld_rw & ~o_dmem_we;
          o_write_reg <= ld_rd;
          if (!o_dmem_we)
            o_result <= load_val;
        end else if (TIMEOUT > 0 && cnt == TLAST) begin
          // abandon the access; the bus never answered
          state       <= IDLE;
          o_dmem_req  <= 1'b0;
          o_valid     <= 1'b1;
          o_write_reg <= ld_rd;
          o_exc       <= 1'b1;
          o_exc_cause <= 2'd3;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed records, queued
// expectations, monitor compares every WB record.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_ALUOutput;
  logic [31:0] i_rd2;
  logic [2:0]  i_func3;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_reg_write;
  logic [4:0]  i_write_reg;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_reg_write;
  logic [4:0]  o_write_reg;
  logic        o_exc;
  logic [1:0]  o_exc_cause;

  mem_stage #(.TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_ALUOutput(i_ALUOutput), .i_rd2(i_rd2),
    .i_func3(i_func3), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_reg_write(i_reg_write),
    .i_write_reg(i_write_reg), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_valid(o_valid),
    .o_result(o_result), .o_reg_write(o_reg_write),
    .o_write_reg(o_write_reg), .o_exc(o_exc),
    .o_exc_cause(o_exc_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] res;
    logic        chk_res;
    logic        rw;
    logic [4:0]  rd;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [31:0] res, logic chk_res,
                      logic rw, logic [4:0] rd,
                      logic exc, logic [1:0] cause);
    exp_t e;
    e.res = res; e.chk_res = chk_res; e.rw = rw;
    e.rd = rd; e.exc = exc; e.cause = cause;
    q.push_back(e);
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_reg_write && !o_valid)
        chk("reg_write_without_valid", 32'(o_reg_write), 0);
      if (o_exc && !o_valid)
        chk("exc_without_valid", 32'(o_exc), 0);
      if (o_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'(o_valid), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_reg_write", 32'(o_reg_write), 32'(e.rw));
          chk("wb_exc", 32'(o_exc), 32'(e.exc));
          if (e.chk_res)
            chk("wb_result", o_result, e.res);
          if (e.rw)
            chk("wb_write_reg", 32'(o_write_reg), 32'(e.rd));
          if (e.exc)
            chk("wb_exc_cause", 32'(o_exc_cause), 32'(e.cause));
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_in();
    i_valid = 0; i_mem_read = 0; i_mem_write = 0;
    i_reg_write = 0; i_func3 = 0; i_ALUOutput = 0;
    i_rd2 = 0; i_write_reg = 0;
  endtask

  task automatic rec(logic [31:0] a, logic [31:0] d,
                     logic [2:0] f3, logic rd_, logic wr,
                     logic rw, logic [4:0] rd);
    i_valid = 1; i_ALUOutput = a; i_rd2 = d; i_func3 = f3;
    i_mem_read = rd_; i_mem_write = wr;
    i_reg_write = rw; i_write_reg = rd;
  endtask

  task automatic load_test(logic [2:0] f3,
                           logic [31:0] exp_res);
    rec(32'h103, 0, f3, 1, 0, 1, 5'd7);
    push(exp_res, 1, 1, 5'd7, 0, 0);
    tick();
    idle_in();
    chk("ld_req", 32'(o_dmem_req), 1);
    chk("ld_stall", 32'(o_stall), 1);
    chk("ld_addr", o_dmem_addr, 32'h100);
    chk("ld_be", 32'(o_dmem_be), 32'hF);
    chk("ld_we", 32'(o_dmem_we), 0);
    i_dmem_ack = 1; i_dmem_rdata = 32'h80FF_0000;
    tick();
    i_dmem_ack = 0;
    chk("ld_stall_after", 32'(o_stall), 0);
    chk("ld_req_after", 32'(o_dmem_req), 0);
  endtask

  initial begin
    i_reset = 1; i_dmem_ack = 0; i_dmem_rdata = 0;
    idle_in();
    tick(); tick();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_req", 32'(o_dmem_req), 0);
    chk("rst_result", o_result, 0);
    chk("rst_cause", 32'(o_exc_cause), 0);
    chk("rst_be", 32'(o_dmem_be), 0);
    i_reset = 0;
    i_dmem_ack = 1;
    tick();
    i_dmem_ack = 0;
    chk("stray_ack_req", 32'(o_dmem_req), 0);
    chk("stray_ack_stall", 32'(o_stall), 0);

    rec(32'h0000_1234, 0, 0, 0, 0, 1, 5'd5);
    push(32'h1234, 1, 1, 5'd5, 0, 0);
    tick();
    idle_in();
    chk("add_req", 32'(o_dmem_req), 0);
    chk("add_valid", 32'(o_valid), 1);
    tick();

    load_test(3'd0, 32'hFFFF_FF80);
    load_test(3'd4, 32'h0000_0080);

    rec(32'h102, 32'h1234_ABCD, 3'd1, 0, 1, 1, 5'd3);
    push(0, 0, 0, 5'd3, 0, 0);
    tick();
    idle_in();
    chk("sh_addr", o_dmem_addr, 32'h100);
    chk("sh_be", 32'(o_dmem_be), 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(o_dmem_we), 1);
    for (int i = 0; i < 3; i++) begin
      chk("sh_req_held", 32'(o_dmem_req), 1);
      chk("sh_wdata_held", o_dmem_wdata, 32'hABCD_ABCD);
      if (i == 2) i_dmem_ack = 1;
      tick();
    end
    i_dmem_ack = 0;
    chk("sh_req_done", 32'(o_dmem_req), 0);
    chk("sh_stall_done", 32'(o_stall), 0);

    rec(32'h102, 0, 3'd2, 1, 0, 1, 5'd4);
    push(0, 0, 0, 0, 1, 2'd1);
    tick();
    chk("mis_req", 32'(o_dmem_req), 0);
    rec(32'h100, 0, 3'd3, 1, 0, 1, 5'd4);
    push(0, 0, 0, 0, 1, 2'd2);
    tick();
    chk("ill_req", 32'(o_dmem_req), 0);
    rec(32'h100, 0, 3'd2, 1, 1, 1, 5'd4);
    push(0, 0, 0, 0, 1, 2'd2);
    tick();
    idle_in();
    chk("rw_req", 32'(o_dmem_req), 0);
    chk("rw_stall", 32'(o_stall), 0);
    tick();

    rec(32'h200, 32'hDEAD_BEEF, 3'd2, 0, 1, 0, 5'd0);
    push(0, 0, 0, 0, 1, 2'd3);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", 32'(o_dmem_req), 1);
      tick();
    end
    chk("to_req_dropped", 32'(o_dmem_req), 0);
    chk("to_stall_dropped", 32'(o_stall), 0);
    i_dmem_ack = 1;
    tick();
    i_dmem_ack = 0;
    chk("late_ack_valid", 32'(o_valid), 0);
    tick();

    rec(32'h200, 0, 3'd2, 1, 0, 1, 5'd9);
    tick();
    idle_in();
    tick();
    chk("rst_wait_req", 32'(o_dmem_req), 1);
    i_reset = 1;
    tick();
    i_reset = 0;
    chk("rstw_req", 32'(o_dmem_req), 0);
    chk("rstw_valid", 32'(o_valid), 0);
    chk("rstw_stall", 32'(o_stall), 0);
    chk("rstw_exc", 32'(o_exc), 0);
    rec(32'h55, 0, 0, 0, 0, 1, 5'd2);
    push(32'h55, 1, 1, 5'd2, 0, 0);
    tick();
    idle_in();
    chk("post_rst_valid", 32'(o_valid), 1);
    tick(); tick();

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32I pipeline, directly downstream of the ALU. It takes the registered ALU result (an effective address or a plain result), the store data and the load/store type. It then drives a single-port data-memory request/acknowledge interface, aligns and extends load data, and hands a write-back record to the WB stage. It stalls the upstream pipeline while a memory access is outstanding.

## Interface
- TIMEOUT, 64, number of request cycles without acknowledge before the access is aborted; 0 disables the watchdog.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  EX record present.
- i_ALUOutput  in  32  effective address (memory ops) or result (all other ops).
- i_rd2  in  32  store data.
- i_func3  in  3  load/store width code (RISC-V encoding).
- i_mem_read, i_mem_write  in  1 each  load / store.
- i_reg_write  in  1  record writes a register.
- i_write_reg  in  5  destination register index.
- o_stall  out  1  upstream must hold its record.
- o_dmem_req  out  1  memory request.
- o_dmem_we  out  1  write request.
- o_dmem_addr  out  32  word address; bits [1:0] are always 0.
- o_dmem_be  out  4  byte enables.
- o_dmem_wdata  out  32  lane-replicated store data.
- i_dmem_ack  in  1  request completed; i_dmem_rdata is valid in the same cycle.
- i_dmem_rdata  in  32  read word.
- o_valid  out  1  WB record valid; asserted for one cycle per accepted record.
- o_result  out  32  write-back value.
- o_reg_write  out  1  WB write enable; never 1 when o_valid is 0.
- o_write_reg  out  5  WB destination register.
- o_exc  out  1  one-cycle pulse: misaligned or illegal access, or bus timeout.
- o_exc_cause  out  2  1 = misaligned, 2 = illegal, 3 = timeout; holds its value between pulses.

## Operation
- FSM with two states, IDLE and WAIT. o_stall = (state == WAIT).
- **Accept rule.** A record is accepted when i_valid is 1 and o_stall is 0.
- **Non-memory record.** o_result = i_ALUOutput, with o_reg_write and o_write_reg copied from the inputs. The FSM stays in IDLE.
- **Legality checks**, applied in this order:
  - read and write both set → illegal;
  - load func3 in {3, 6, 7} or store func3 ≥ 3 → illegal;
  - halfword access with addr[0] = 1, or word access with addr[1:0] ≠ 0 → misaligned.
- **Faulting record.** No memory request is issued. The stage emits o_valid = 1, o_reg_write = 0 and an o_exc pulse with the matching cause. The FSM stays in IDLE.
- **Legal memory record.** The stage latches the request and goes to WAIT.
  - o_dmem_addr = {addr[31:2], 2'b00}.
  - Byte enables: SB → 4'b0001 << addr[1:0]; SH → 4'b0011 << {addr[1], 1'b0}; SW → 4'b1111. Loads → 4'b1111.
  - Store data: SB → byte replicated ×4; SH → halfword replicated ×2; SW → unchanged.
- **WAIT state.** o_dmem_req = 1, with addr, be, we and wdata held stable until ack.
  - On i_dmem_ack: go to IDLE and register the WB record.
  - Load result: select the byte or halfword lane by addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word unchanged.
  - Stores produce o_reg_write = 0.
- **Watchdog.** A cycle counter (width clog2(TIMEOUT+1)) counts request cycles in WAIT. If TIMEOUT > 0 and TIMEOUT cycles elapse with no ack, the stage drops the request and goes to IDLE. It then emits o_valid = 1, o_reg_write = 0, o_exc = 1 and o_exc_cause = 3.
- **Ack outside a request.** i_dmem_ack is ignored whenever o_dmem_req is 0.
- **Reset values.** All outputs are 0 and the state is IDLE. An ack arriving after reset is ignored. A reset asserted during WAIT abandons the access, with no write-back and no exception.

## Timing
- Non-memory or faulting record accepted at cycle N → o_valid at N+1. Throughput is one record per cycle.
- Memory record accepted at cycle N → o_dmem_req = 1 from N+1. Ack sampled at cycle M ≥ N+1 → o_valid at M+1, with o_stall low at M+1, so the next record can be accepted at M+1.
- o_stall is high from N+1 through M inclusive. A zero-wait-state memory therefore costs one stall cycle per access.
- Timeout: request cycles run N+1 … N+TIMEOUT; o_exc and o_valid at N+TIMEOUT+1.
- o_result, o_write_reg and o_dmem_* hold their last values while their valid or req signal is low.

## Test plan
- ADD result 0x0000_1234 with rd = 5 (no memory op) → o_valid = 1 one cycle later, with o_result = 0x1234 and o_write_reg = 5. o_dmem_req is never asserted.
- LB at address 0x103 with ack in the first request cycle and rdata 0x80FF_0000 → addr = 0x100, be = 4'b1111, one stall cycle, o_result = 0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- SH at address 0x102 with data 0x1234_ABCD and ack after 3 cycles → be = 4'b1100, wdata = 0xABCD_ABCD, we = 1, request held 3 cycles, o_valid with o_reg_write = 0.
- LW at address 0x102 → no request, o_exc = 1 with cause 1. func3 = 3 on a load → cause 2. Read and write both set → cause 2.
- SW with TIMEOUT = 4 and no ack → req high exactly 4 cycles, then o_exc with cause 3. A late ack one cycle after the abort produces no o_valid.
- Reset asserted in the second WAIT cycle → req = 0, o_valid = 0 and o_stall = 0 next cycle. A subsequent ADD completes normally.
